fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction-fetch front end consuming next-PC redirects and driving the instruction memory.
//  Holds a word-aligned fetch PC and issues in-order read requests with a valid/ready handshake.
//  Buffers returned words with their PCs in a DEPTH-entry queue and presents them to decode via valid/ready.
//  On a branch/JALR redirect it flushes the queue and discards responses to already-issued requests.
// PARAMETERS
//  DEPTH     4             queue entries; also the credit limit (queued + in-flight); power of 2, >=2
//  RESET_PC  32'h0040_0000 fetch PC after reset
// PORTS
//  clock          in   1   single clock, rising edge
//  reset          in   1   asynchronous, active-low
//  redirect_valid in   1   one-cycle pulse: branch/JALR target available
//  redirect_addr  in   32  target PC; bits [1:0] ignored (forced 0)
//  imem_req_valid out  1   read request valid
//  imem_req_ready in   1   memory accepts request
//  imem_req_addr  out  32  request address (word aligned)
//  imem_rsp_valid in   1   read data valid; one per accepted request, in order, >=1 cycle after acceptance
//  imem_rsp_data  in   32  instruction word
//  inst_valid     out  1   instruction available to decode
//  inst_ready     in   1   decode accepts instruction
//  inst_data      out  32  instruction word
//  inst_pc        out  32  PC of inst_data
// BEHAVIOUR
//  - Reset (reset=0, any time, including mid-transfer): fetch_pc=RESET_PC, rsp_pc=RESET_PC, count=0,
//    inflight=0, drop_cnt=0; imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0. Reset overrides redirect.
//  - Request: imem_req_valid = (count + inflight < DEPTH) && !redirect_valid; imem_req_addr = fetch_pc.
//    On req_valid && req_ready: fetch_pc += 4 (32-bit wrap), inflight++.
//  - imem_req_addr is held stable while imem_req_valid=1 and imem_req_ready=0.
//  - Response: every imem_rsp_valid decrements inflight. If drop_cnt>0: word discarded, drop_cnt--.
//    Else word pushed with tag rsp_pc, rsp_pc += 4. Credit rule guarantees the queue never overflows.
//  - Decode side: inst_valid = (count>0); inst_data/inst_pc = head entry; pop on inst_valid && inst_ready.
//    Head held stable while inst_valid && !inst_ready. Push+pop same cycle: count unchanged.
//  - Latency (no bypass): response at edge N -> inst_valid visible after edge N (next cycle).
//  - Redirect (redirect_valid=1 in cycle C): at edge C queue flushed (count=0), fetch_pc and rsp_pc =
//    {redirect_addr[31:2],2'b00}; drop_cnt = inflight minus any response arriving in C (that response is
//    discarded); imem_req_valid=0 during C; inst_valid=0 from C+1; any pop in C is still honoured.
//  - Redirect while drop_cnt>0: drop_cnt recomputed as above (all older in-flight responses discarded).
//  - Invariant: drop_cnt <= inflight <= DEPTH; count + inflight <= DEPTH.
// CONFIGURATION
//  - FETCH_QUEUE_BYPASS_EN defined: when count==0, drop_cnt==0, imem_rsp_valid=1 and no redirect, inst_valid=1
//    combinationally that cycle with inst_data=imem_rsp_data, inst_pc=rsp_pc; if inst_ready=1 the word
//    is consumed and not written to the queue, else it is enqueued normally.
//  - Undefined: no combinational rsp->inst path; all outputs registered/queue-driven (one-cycle latency).
// TESTING
//  1. Hold reset=0 3 cycles, release -> imem_req_valid=1, imem_req_addr=0x0040_0000, inst_valid=0.
//  2. Memory ready=1, 1-cycle data, inst_ready=1 -> inst_pc 0x400000,0x400004,0x400008 in order, data matches.
//  3. inst_ready=0, 1-cycle data -> exactly 4 requests, then imem_req_valid=0 with count=4; raise inst_ready
//     -> 4 words drain in order, requests resume at 0x400010.
//  4. 2 requests in flight, redirect to 0x0040_0100 -> both responses discarded; next inst_pc=0x400100.
//  5. Redirect to 0x0040_0102 with response arriving same cycle -> response dropped; imem_req_addr=0x400100.
//  6. Empty queue, rsp_valid with inst_ready=1 -> with FETCH_QUEUE_BYPASS_EN inst_valid same cycle;
//     without it, inst_valid the following cycle; same data and PC in both builds.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC, in-order imem requests, DEPTH-entry instruction queue.
// Define FETCH_QUEUE_BYPASS_EN for a same-cycle rsp->decode path on an empty queue.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [CW:0]   used;
  logic [31:0]   target;
  logic          req_fire;
  logic          take;
  logic          byp;
  logic          byp_fire;
  logic          push;
  logic          pop;

  assign target   = redirect_addr & ~32'h3;
  assign used     = {1'b0, count} + {1'b0, inflight};
  // credits cover queued words plus in-flight requests, so no overflow
  assign imem_req_valid = reset && !redirect_valid
                       && (used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign take     = imem_rsp_valid && (drop_cnt == '0)
                 && !redirect_valid;
  assign pop      = (count != '0) && inst_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = reset && take && (count == '0);
`else
  assign byp = 1'b0;
`endif

  assign byp_fire = byp && inst_ready;
  assign push     = take && !byp_fire;

  always_comb begin
    inst_valid = (count != '0) || byp;
    inst_data  = data_q[rd_ptr];
    inst_pc    = pc_q[rd_ptr];
    if (byp) begin
      inst_data = imem_rsp_data;
      inst_pc   = rsp_pc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      inflight <= inflight + CW'(req_fire)
                - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= target;
        rsp_pc   <= target;
        // a response landing this cycle is already gone
        drop_cnt <= inflight - CW'(imem_rsp_valid);
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req_fire)
          fetch_pc <= fetch_pc + 32'd4;
        if (take)
          rsp_pc <= rsp_pc + 32'd4;
        if (imem_rsp_valid && (drop_cnt != '0))
          drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          data_q[wr_ptr] <= imem_rsp_data;
          pc_q[wr_ptr]   <= rsp_pc;
          wr_ptr         <= wr_ptr + AW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios for fetch_queue.
// Memory model answers each accepted request one cycle later when enabled.
`timescale 1ns/1ps
module tb_fetch_queue;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int          n_vec = 0;
  int          n_bad = 0;
  logic        mem_on = 1'b0;
  logic [31:0] pend[$];
  logic [31:0] acc_q[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_data[$];

  fetch_queue dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hdead_beef;
  endfunction

  task automatic tick();
    @(negedge clock);
    if (imem_req_valid && imem_req_ready) begin
      pend.push_back(imem_req_addr);
      acc_q.push_back(imem_req_addr);
    end
    if (inst_valid && inst_ready) begin
      got_pc.push_back(inst_pc);
      got_data.push_back(inst_data);
    end
    @(posedge clock);
    #1;
    redirect_valid = 1'b0;
    if (mem_on && pend.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b0;
    mem_on         = 1'b0;
    repeat (3) tick();
    pend.delete();
    acc_q.delete();
    got_pc.delete();
    got_data.delete();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++;
      $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    n_vec++; if (inst_valid !== 1'b0) begin n_bad++;
      $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
    n_vec++; if (inst_data !== 32'h0) begin n_bad++;
      $display("FAIL rst_inst_data: got %h want 0", inst_data); end
    n_vec++; if (inst_pc !== 32'h0) begin n_bad++;
      $display("FAIL rst_inst_pc: got %h want 0", inst_pc); end
    reset = 1'b1;
    #1;
    n_vec++; if (imem_req_valid !== 1'b1) begin n_bad++;
      $display("FAIL rel_req_valid: got %b want 1", imem_req_valid); end
    n_vec++; if (imem_req_addr !== 32'h0040_0000) begin n_bad++;
      $display("FAIL rel_req_addr: got %h want 00400000", imem_req_addr); end
    n_vec++; if (inst_valid !== 1'b0) begin n_bad++;
      $display("FAIL rel_inst_valid: got %b want 0", inst_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    mem_on         = 1'b1;
    for (int i = 0; i < 20 && got_pc.size() < 3; i++) tick();
    n_vec++;
    if (got_pc.size() < 3) begin n_bad++;
      $display("FAIL stream_count: got %0d want 3", got_pc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        e = 32'h0040_0000 + 32'(4 * k);
        n_vec++; if (got_pc[k] !== e) begin n_bad++;
          $display("FAIL stream_pc%0d: got %h want %h", k, got_pc[k], e); end
        n_vec++; if (got_data[k] !== word_of(e)) begin n_bad++;
          $display("FAIL stream_data%0d: got %h want %h", k, got_data[k], word_of(e)); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    mem_on         = 1'b1;
    repeat (10) tick();
    n_vec++; if (acc_q.size() != 4) begin n_bad++;
      $display("FAIL bp_nreq: got %0d want 4", acc_q.size()); end
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++;
      $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
    n_vec++; if (inst_valid !== 1'b1) begin n_bad++;
      $display("FAIL bp_inst_valid: got %b want 1", inst_valid); end
    n_vec++; if (inst_pc !== 32'h0040_0000) begin n_bad++;
      $display("FAIL bp_head_pc: got %h want 00400000", inst_pc); end
    inst_ready = 1'b1;
    for (int i = 0; i < 20 && got_pc.size() < 4; i++) tick();
    n_vec++;
    if (got_pc.size() < 4) begin n_bad++;
      $display("FAIL bp_drain: got %0d want 4", got_pc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        e = 32'h0040_0000 + 32'(4 * k);
        n_vec++; if (got_pc[k] !== e) begin n_bad++;
          $display("FAIL bp_pc%0d: got %h want %h", k, got_pc[k], e); end
        n_vec++; if (got_data[k] !== word_of(e)) begin n_bad++;
          $display("FAIL bp_data%0d: got %h want %h", k, got_data[k], word_of(e)); end
      end
    end
    n_vec++;
    if (acc_q.size() < 5) begin n_bad++;
      $display("FAIL bp_resume: got %0d reqs want >=5", acc_q.size());
    end else if (acc_q[4] !== 32'h0040_0010) begin n_bad++;
      $display("FAIL bp_resume: got %h want 00400010", acc_q[4]);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    repeat (2) tick();
    imem_req_ready = 1'b0;
    n_vec++; if (acc_q.size() != 2) begin n_bad++;
      $display("FAIL rd_inflight: got %0d want 2", acc_q.size()); end
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0040_0100;
    #1;
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++;
      $display("FAIL rd_req_block: got %b want 0", imem_req_valid); end
    tick();
    n_vec++; if (inst_valid !== 1'b0) begin n_bad++;
      $display("FAIL rd_flush: got %b want 0", inst_valid); end
    n_vec++; if (imem_req_addr !== 32'h0040_0100) begin n_bad++;
      $display("FAIL rd_addr: got %h want 00400100", imem_req_addr); end
    mem_on         = 1'b1;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 20 && got_pc.size() < 1; i++) tick();
    n_vec++;
    if (got_pc.size() < 1) begin n_bad++;
      $display("FAIL rd_first: got none want 00400100");
    end else begin
      n_vec++; if (got_pc[0] !== 32'h0040_0100) begin n_bad++;
        $display("FAIL rd_pc: got %h want 00400100", got_pc[0]); end
      n_vec++; if (got_data[0] !== word_of(32'h0040_0100)) begin n_bad++;
        $display("FAIL rd_data: got %h want %h", got_data[0], word_of(32'h0040_0100)); end
    end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    mem_on         = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0040_0102;
    #1;
    n_vec++; if (imem_req_valid !== 1'b0) begin n_bad++;
      $display("FAIL sc_req_block: got %b want 0", imem_req_valid); end
    tick();
    n_vec++; if (inst_valid !== 1'b0) begin n_bad++;
      $display("FAIL sc_dropped: got %b want 0", inst_valid); end
    n_vec++; if (imem_req_addr !== 32'h0040_0100) begin n_bad++;
      $display("FAIL sc_addr: got %h want 00400100", imem_req_addr); end
    n_vec++; if (imem_req_valid !== 1'b1) begin n_bad++;
      $display("FAIL sc_req_valid: got %b want 1", imem_req_valid); end
    inst_ready = 1'b1;
    for (int i = 0; i < 20 && got_pc.size() < 1; i++) tick();
    n_vec++;
    if (got_pc.size() < 1) begin n_bad++;
      $display("FAIL sc_first: got none want 00400100");
    end else begin
      n_vec++; if (got_pc[0] !== 32'h0040_0100) begin n_bad++;
        $display("FAIL sc_pc: got %h want 00400100", got_pc[0]); end
      n_vec++; if (got_data[0] !== word_of(32'h0040_0100)) begin n_bad++;
        $display("FAIL sc_data: got %h want %h", got_data[0], word_of(32'h0040_0100)); end
    end
  endtask

  task automatic test_empty_latency();
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word_of(pend.pop_front());
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    n_vec++; if (inst_valid !== 1'b1) begin n_bad++;
      $display("FAIL byp_valid: got %b want 1", inst_valid); end
    n_vec++; if (inst_pc !== 32'h0040_0000) begin n_bad++;
      $display("FAIL byp_pc: got %h want 00400000", inst_pc); end
    tick();
`else
    n_vec++; if (inst_valid !== 1'b0) begin n_bad++;
      $display("FAIL lat_valid0: got %b want 0", inst_valid); end
    tick();
    n_vec++; if (inst_valid !== 1'b1) begin n_bad++;
      $display("FAIL lat_valid1: got %b want 1", inst_valid); end
    n_vec++; if (inst_pc !== 32'h0040_0000) begin n_bad++;
      $display("FAIL lat_pc: got %h want 00400000", inst_pc); end
    tick();
`endif
    n_vec++; if (inst_valid !== 1'b0) begin n_bad++;
      $display("FAIL empty_after: got %b want 0", inst_valid); end
    n_vec++;
    if (got_pc.size() != 1) begin n_bad++;
      $display("FAIL empty_count: got %0d want 1", got_pc.size());
    end else begin
      n_vec++; if (got_pc[0] !== 32'h0040_0000) begin n_bad++;
        $display("FAIL empty_pc: got %h want 00400000", got_pc[0]); end
      n_vec++; if (got_data[0] !== word_of(32'h0040_0000)) begin n_bad++;
        $display("FAIL empty_data: got %h want %h", got_data[0], word_of(32'h0040_0000)); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_same_cycle();
    test_empty_latency();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
